csa_pipe_adder: RTL and testbench

- Parametrised, pipelined carry-select adder/subtractor; the next generation of the fixed 64-bit, 8-bit-block combinational carry-select adder.
- Splits the operand into BLK-bit carry-select segments and groups SEGS_PER_STAGE segments per pipeline stage.
- Adds add/subtract mode, signed-overflow flag and valid/ready handshakes on both sides.
- Sits between operand-issue logic and result-consuming logic in the datapath; throughput 1 op/cycle.

---
 rtl/csa_pipe_pkg.sv | 17 +
 rtl/csa_segment.sv | 37 +++
 rtl/csa_pipe_adder.sv | 112 +++++++++++
 tb/tb_csa_pipe_adder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pipe_pkg.sv
// Sizing helpers shared by the pipelined carry-select adder and its segment cells.
package csa_pipe_pkg;

    function automatic bit params_ok(input int width, input int blk, input int segs);
        return (blk >= 1) && (segs >= 1) && (width >= blk * segs) && (width % (blk * segs) == 0);
    endfunction

    function automatic int stage_width(input int blk, input int segs);
        return blk * segs;
    endfunction

    // Falls back to one stage for illegal parameters so elaboration reaches the fatal check.
    function automatic int nstage(input int width, input int blk, input int segs);
        return params_ok(width, blk, segs) ? width / stage_width(blk, segs) : 1;
    endfunction

endpackage

// File: rtl/csa_segment.sv
// Combinational BLK-bit carry-select cell: two ripple chains (cin=0/1) and a late select on cin.
module csa_segment #(
    parameter int BLK = 8
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] sum,
    output logic           cout,
    output logic           cmsb
);

    logic [BLK:0]   c0;
    logic [BLK:0]   c1;
    logic [BLK-1:0] s0;
    logic [BLK-1:0] s1;

    always_comb begin
        c0 = '0;
        c1 = '0;
        s0 = '0;
        s1 = '0;
        c1[0] = 1'b1;
        for (int i = 0; i < BLK; i++) begin
            s0[i]   = a[i] ^ b[i] ^ c0[i];
            c0[i+1] = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
            s1[i]   = a[i] ^ b[i] ^ c1[i];
            c1[i+1] = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
        end
    end

    // c1 dominates c0 bitwise, so the OR/AND form equals a mux on cin.
    assign sum  = cin ? s1 : s0;
    assign cout = c0[BLK] | (c1[BLK] & cin);
    assign cmsb = c0[BLK-1] | (c1[BLK-1] & cin);

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor; each stage resolves S = BLK*SEGS_PER_STAGE bits
// and shifts the partially-resolved word forward, so latency is NSTAGE cycles.
module csa_pipe_adder
    import csa_pipe_pkg::*;
#(
    parameter int WIDTH          = 64,
    parameter int BLK            = 8,
    parameter int SEGS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int S      = stage_width(BLK, SEGS_PER_STAGE);
    localparam int NSTAGE = nstage(WIDTH, BLK, SEGS_PER_STAGE);

    if (!params_ok(WIDTH, BLK, SEGS_PER_STAGE)) begin : g_param_check
        $fatal(1, "csa_pipe_adder: WIDTH must be a multiple of BLK*SEGS_PER_STAGE with BLK >= 1");
    end

    logic en;

    // Index k is the input of stage k; index NSTAGE is the output register bank.
    logic [WIDTH-1:0]          pa  [NSTAGE+1];
    logic [WIDTH-1:0]          pb  [NSTAGE+1];
    logic                      pcy [NSTAGE+1];
    logic                      pv  [NSTAGE+1];
    logic [SEGS_PER_STAGE-1:0] pov [NSTAGE+1];

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    assign pa[0]  = a;
    assign pb[0]  = b ^ {WIDTH{sub}};
    assign pcy[0] = sub | c_in;
    assign pv[0]  = in_valid;
    assign pov[0] = '0;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        logic [SEGS_PER_STAGE:0]   ch;
        logic [S-1:0]              seg_sum;
        logic [SEGS_PER_STAGE-1:0] seg_cmsb;
        logic [SEGS_PER_STAGE-1:0] seg_ov;
        logic [WIDTH-1:0]          a_nxt;
        logic [WIDTH-1:0]          a_r;
        logic [WIDTH-1:0]          b_r;
        logic                      cy_r;
        logic                      v_r;
        logic [SEGS_PER_STAGE-1:0] ov_r;

        assign ch[0] = pcy[k];

        for (genvar j = 0; j < SEGS_PER_STAGE; j++) begin : g_seg
            csa_segment #(.BLK(BLK)) u_seg (
                .a    (pa[k][k*S + j*BLK +: BLK]),
                .b    (pb[k][k*S + j*BLK +: BLK]),
                .cin  (ch[j]),
                .sum  (seg_sum[j*BLK +: BLK]),
                .cout (ch[j+1]),
                .cmsb (seg_cmsb[j])
            );
            // Only the top segment of the last stage feeds ovf.
            assign seg_ov[j] = ch[j+1] ^ seg_cmsb[j];
        end

        // Resolved sum bits overwrite the consumed operand-A slice.
        always_comb begin
            a_nxt = pa[k];
            a_nxt[k*S +: S] = seg_sum;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_r <= 1'b0;
                if (k == NSTAGE - 1) begin
                    a_r  <= '0;
                    cy_r <= 1'b0;
                    ov_r <= '0;
                end
            end else if (en) begin
                v_r  <= pv[k];
                a_r  <= a_nxt;
                b_r  <= pb[k];
                cy_r <= ch[SEGS_PER_STAGE];
                ov_r <= seg_ov;
            end
        end

        assign pa[k+1]  = a_r;
        assign pb[k+1]  = b_r;
        assign pcy[k+1] = cy_r;
        assign pv[k+1]  = v_r;
        assign pov[k+1] = ov_r;
    end

    assign sum       = pa[NSTAGE];
    assign c_out     = pcy[NSTAGE];
    assign ovf       = pov[NSTAGE][SEGS_PER_STAGE-1];
    assign out_valid = pv[NSTAGE];

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Self-checking bench for csa_pipe_adder against an arithmetic reference model.
module tb_csa_pipe_adder;
    localparam int WIDTH = 64;
    localparam int LAT   = 4;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             c_out;
        logic             ovf;
    } res_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             ci;
        logic             s;
        logic [WIDTH-1:0] sum;
        logic             co;
        logic             ov;
    } dvec_t;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             c_in      = 1'b0;
    logic             sub       = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    int    checks = 0;
    int    errors = 0;
    res_t  exp_q[$];
    dvec_t dvec [7];

    always #5 clk = ~clk;

    csa_pipe_adder #(.WIDTH(WIDTH), .BLK(8), .SEGS_PER_STAGE(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    // Plain arithmetic: sum mod 2^W, carry/no-borrow, and whether the exact signed result fits in W bits.
    function automatic res_t ref_model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                       input logic ci, input logic s);
        res_t             r;
        logic [WIDTH:0]   u;
        logic [WIDTH+1:0] sx;
        logic [WIDTH+1:0] sy;
        logic [WIDTH+1:0] wide;
        sx = {{2{x[WIDTH-1]}}, x};
        sy = {{2{y[WIDTH-1]}}, y};
        if (s) begin
            r.sum   = x - y;
            r.c_out = (x >= y);
            wide    = sx - sy;
        end else begin
            u       = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
            r.sum   = u[WIDTH-1:0];
            r.c_out = u[WIDTH];
            wide    = sx + sy + {{(WIDTH+1){1'b0}}, ci};
        end
        r.ovf = (wide[WIDTH+1:WIDTH-1] != 3'b000) && (wide[WIDTH+1:WIDTH-1] != 3'b111);
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return '1;
            1:       return '0;
            2:       return {1'b0, {(WIDTH-1){1'b1}}};
            3:       return {1'b1, {(WIDTH-1){1'b0}}};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // One clock: drive at the falling edge, observe 1 time unit later, then advance a full cycle.
    task automatic drive(input logic v, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic ci, input logic s, input logic rdy,
                         output logic acc, output logic ohs, output logic irdy,
                         output logic ovld, output res_t got);
        in_valid  = v;
        a         = x;
        b         = y;
        c_in      = ci;
        sub       = s;
        out_ready = rdy;
        #1;
        acc  = in_valid && in_ready;
        ohs  = out_valid && out_ready;
        irdy = in_ready;
        ovld = out_valid;
        got  = {sum, c_out, ovf};
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (sum !== '0) begin errors++; $display("FAIL reset_sum got=%h want=0", sum); end
        checks++; if (c_out !== 1'b0) begin errors++; $display("FAIL reset_c_out got=%b want=0", c_out); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b want=0", ovf); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_directed();
        dvec[0] = {64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0};
        dvec[1] = {64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        dvec[2] = {64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0};
        dvec[3] = {64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        dvec[4] = {64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        dvec[5] = {64'd1, 64'd2, 1'b1, 1'b0, 64'd4, 1'b0, 1'b0};
        dvec[6] = {64'd7, 64'd5, 1'b1, 1'b1, 64'd2, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            int   n;
            logic acc, ohs, irdy, ovld;
            res_t got, want;
            want = {dvec[i].sum, dvec[i].co, dvec[i].ov};
            drive(1'b1, dvec[i].a, dvec[i].b, dvec[i].ci, dvec[i].s, 1'b1, acc, ohs, irdy, ovld, got);
            checks++; if (acc !== 1'b1) begin errors++; $display("FAIL dir%0d_accept got=%b want=1", i, acc); end
            n = 0;
            do begin
                n++;
                drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, ohs, irdy, ovld, got);
            end while (!ohs && n < 20);
            checks++;
            if (n !== LAT) begin errors++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, n, LAT); end
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL dir%0d_result got sum=%h c_out=%b ovf=%b want sum=%h c_out=%b ovf=%b",
                         i, got.sum, got.c_out, got.ovf, want.sum, want.c_out, want.ovf);
            end
        end
    endtask

    task automatic test_back_to_back();
        int               issued = 0;
        int               got_n  = 0;
        int               c      = 0;
        logic             acc, ohs, irdy, ovld, ci, s, stall;
        logic             have_held = 1'b0;
        logic [WIDTH-1:0] x, y;
        res_t             got, held;
        exp_q.delete();
        while ((issued < 8 || got_n < 8) && c < 60) begin
            x     = {$urandom, $urandom};
            y     = {$urandom, $urandom};
            ci    = 1'($urandom_range(0, 1));
            s     = 1'($urandom_range(0, 1));
            stall = (c >= 5 && c <= 7);
            drive(issued < 8, x, y, ci, s, !stall, acc, ohs, irdy, ovld, got);
            if (stall) begin
                checks++; if (ovld !== 1'b1) begin errors++; $display("FAIL b2b_stall_out_valid c=%0d got=%b want=1", c, ovld); end
                checks++; if (irdy !== 1'b0) begin errors++; $display("FAIL b2b_stall_in_ready c=%0d got=%b want=0", c, irdy); end
                if (have_held) begin
                    checks++;
                    if (got !== held) begin errors++; $display("FAIL b2b_hold c=%0d got=%h want=%h", c, got, held); end
                end
                held = got;
                have_held = 1'b1;
            end
            if (ohs) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra_output got sum=%h want none", got.sum);
                end else begin
                    if (got !== exp_q[0]) begin
                        errors++; $display("FAIL b2b_result n=%0d got=%h want=%h", got_n, got, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                got_n++;
            end
            if (acc) begin
                exp_q.push_back(ref_model(x, y, ci, s));
                issued++;
            end
            c++;
        end
        checks++;
        if (issued !== 8 || got_n !== 8) begin
            errors++; $display("FAIL b2b_count got issued=%0d results=%0d want 8/8", issued, got_n);
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, ohs, irdy, ovld, got);
            checks++; if (ohs !== 1'b0) begin errors++; $display("FAIL b2b_duplicate got out_valid=%b want=0", ohs); end
        end
    endtask

    task automatic test_random();
        int               issued = 0;
        int               got_n  = 0;
        int               c      = 0;
        logic             acc, ohs, irdy, ovld, ci, s, v, rdy;
        logic [WIDTH-1:0] x, y;
        res_t             got;
        exp_q.delete();
        while ((issued < 10000 || got_n < issued) && c < 40000) begin
            x   = rand_operand();
            y   = rand_operand();
            ci  = 1'($urandom_range(0, 1));
            s   = 1'($urandom_range(0, 1));
            v   = (issued < 10000) && ($urandom_range(0, 4) != 0);
            rdy = (issued >= 10000) || ($urandom_range(0, 3) != 0);
            drive(v, x, y, ci, s, rdy, acc, ohs, irdy, ovld, got);
            if (ohs) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rnd_extra_output got sum=%h want none", got.sum);
                end else begin
                    if (got !== exp_q[0]) begin
                        errors++; $display("FAIL rnd_result n=%0d got=%h want=%h", got_n, got, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                got_n++;
            end
            if (acc) begin
                exp_q.push_back(ref_model(x, y, ci, s));
                issued++;
            end
            c++;
        end
        checks++;
        if (got_n !== 10000) begin errors++; $display("FAIL rnd_count got=%0d want=10000", got_n); end
    endtask

    task automatic test_reset_flush();
        int               n;
        logic             acc, ohs, irdy, ovld;
        logic [WIDTH-1:0] x, y;
        res_t             got, want;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, rand_operand(), rand_operand(), 1'b0, 1'b0, 1'b1, acc, ohs, irdy, ovld, got);
            checks++; if (acc !== 1'b1) begin errors++; $display("FAIL flush_accept%0d got=%b want=1", i, acc); end
        end
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, ohs, irdy, ovld, got);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, ohs, irdy, ovld, got);
            checks++; if (ovld !== 1'b0) begin errors++; $display("FAIL flush_stale cyc=%0d got out_valid=%b want=0", i, ovld); end
            if (i == 0) begin
                checks++; if (got !== '0) begin errors++; $display("FAIL flush_out_regs got=%h want=0", got); end
            end
        end
        x    = {$urandom, $urandom};
        y    = {$urandom, $urandom};
        want = ref_model(x, y, 1'b1, 1'b0);
        drive(1'b1, x, y, 1'b1, 1'b0, 1'b1, acc, ohs, irdy, ovld, got);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL flush_new_accept got=%b want=1", acc); end
        n = 0;
        do begin
            n++;
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, ohs, irdy, ovld, got);
        end while (!ohs && n < 20);
        checks++; if (n !== LAT) begin errors++; $display("FAIL flush_new_latency got=%0d want=%0d", n, LAT); end
        checks++; if (got !== want) begin errors++; $display("FAIL flush_new_result got=%h want=%h", got, want); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
